packet_arbiter: RTL and testbench

PACKET_ARBITER -- requirements
Module: packet_arbiter

---
 rtl/packet_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/packet_arbiter.sv | 155 +++++++++++++++
 tb/tb_packet_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared definitions for the packet arbiter: beat widths and the arbiter FSM
// state encoding.
package packet_pkg;

    localparam int PKT_DATA_W = 64;
    localparam int PKT_BE_W   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at the source after
// last_grant and wraps, so the most recent owner has the lowest priority.
module rr_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]         iReq,
    input  logic [$clog2(NUM_SRC)-1:0] iLast_grant,
    output logic [$clog2(NUM_SRC)-1:0] oGrant,
    output logic                       oAny
);

    localparam int GW = $clog2(NUM_SRC);
    // One extra bit so last_grant + offset cannot overflow before the wrap.
    localparam logic [GW:0] NUM_W = (GW+1)'(NUM_SRC);

    logic [GW:0] idx;

    // Walk the sources in rotating order and take the first requester.
    always_comb begin
        oGrant = '0;
        oAny   = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = {1'b0, iLast_grant} + (GW+1)'(i);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!oAny && iReq[idx[GW-1:0]]) begin
                oAny   = 1'b1;
                oGrant = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-level arbiter: merges NUM_SRC beat streams into one, locking the
// output to a single source from sop through eop. Beats are registered, so
// each accepted beat appears on the merged stream one cycle later.
// Optional per-source packet counters: define PACKET_ARBITER_STATS_EN.
//
// state  | meaning
// IDLE   | no owner; sop requests are arbitrated and the winner registered
// LOCKED | oGrant owns the output; its beats are accepted until eop
module packet_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic                          iClk,
    input  logic                          iReset,
    input  logic [NUM_SRC-1:0]            iValid,
    input  logic [NUM_SRC*PKT_DATA_W-1:0] iPacket,
    input  logic [NUM_SRC-1:0]            iSop,
    input  logic [NUM_SRC-1:0]            iEop,
    input  logic [NUM_SRC*PKT_BE_W-1:0]   iByte_enable,
    output logic [NUM_SRC-1:0]            oReady,
    output logic                          oValid,
    output logic [PKT_DATA_W-1:0]         oPacket,
    output logic                          oSop,
    output logic                          oEop,
    output logic [PKT_BE_W-1:0]           oByte_enable,
    output logic [$clog2(NUM_SRC)-1:0]    oGrant,
`ifdef PACKET_ARBITER_STATS_EN
    output logic [NUM_SRC*16-1:0]         oPkt_count,
    input  logic                          iClear_stats,
`endif
    output logic                          oBusy
);

    localparam int GW = $clog2(NUM_SRC);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_SRC - 1);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   rr_grant;
    logic            rr_any;
    logic [NUM_SRC-1:0] req;
    logic            accept;
    logic            accept_eop;

    logic [PKT_DATA_W-1:0] pkt_arr [NUM_SRC];
    logic [PKT_BE_W-1:0]   be_arr  [NUM_SRC];

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_unpack
        assign pkt_arr[n] = iPacket[n*PKT_DATA_W +: PKT_DATA_W];
        assign be_arr[n]  = iByte_enable[n*PKT_BE_W +: PKT_BE_W];
    end

    // A bare valid without sop is never a request.
    assign req = iValid & iSop;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .iReq        (req),
        .iLast_grant (last_q),
        .oGrant      (rr_grant),
        .oAny        (rr_any)
    );

    assign accept     = (state_q == LOCKED) && iValid[grant_q];
    assign accept_eop = accept && iEop[grant_q];
    assign oGrant     = grant_q;
    assign oBusy      = (state_q == LOCKED);

    // Ready comes only from registered state so no path exists from iValid.
    always_comb begin
        oReady = '0;
        if (state_q == LOCKED) begin
            oReady[grant_q] = 1'b1;
        end
    end

    // Next-state: lock on a won request, release after the eop beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_grant;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept_eop) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and grant registers; last_grant resets so source 0 wins first.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Output beat register: strobes pulse per accepted beat, payload holds.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oValid       <= 1'b0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
            oPacket      <= '0;
            oByte_enable <= '0;
        end else begin
            oValid <= accept;
            oSop   <= accept && iSop[grant_q];
            oEop   <= accept_eop;
            if (accept) begin
                oPacket      <= pkt_arr[grant_q];
                oByte_enable <= be_arr[grant_q];
            end
        end
    end

`ifdef PACKET_ARBITER_STATS_EN
    logic [15:0] cnt_q [NUM_SRC];

    // Completed-packet counters; clear takes priority over a same-cycle eop.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int n = 0; n < NUM_SRC; n++) begin
                cnt_q[n] <= '0;
            end
        end else if (iClear_stats) begin
            for (int n = 0; n < NUM_SRC; n++) begin
                cnt_q[n] <= '0;
            end
        end else if (accept_eop) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
        end
    end

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_cnt
        assign oPkt_count[n*16 +: 16] = cnt_q[n];
    end
`endif

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter with two sources. Inputs change 1 ns
// after the rising edge and outputs are checked at the same point.
module tb_packet_arbiter;

    localparam int N = 2;

    logic            iClk = 1'b0;
    logic            iReset;
    logic [N-1:0]    iValid, iSop, iEop;
    logic [N*64-1:0] iPacket;
    logic [N*8-1:0]  iByte_enable;
    logic [N-1:0]    oReady;
    logic            oValid, oSop, oEop, oBusy;
    logic [63:0]     oPacket;
    logic [7:0]      oByte_enable;
    logic [0:0]      oGrant;
`ifdef PACKET_ARBITER_STATS_EN
    logic [N*16-1:0] oPkt_count;
    logic            iClear_stats;
`endif

    int checks = 0;
    int errors = 0;

    packet_arbiter #(.NUM_SRC(N)) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iValid       (iValid),
        .iPacket      (iPacket),
        .iSop         (iSop),
        .iEop         (iEop),
        .iByte_enable (iByte_enable),
        .oReady       (oReady),
        .oValid       (oValid),
        .oPacket      (oPacket),
        .oSop         (oSop),
        .oEop         (oEop),
        .oByte_enable (oByte_enable),
        .oGrant       (oGrant),
`ifdef PACKET_ARBITER_STATS_EN
        .oPkt_count   (oPkt_count),
        .iClear_stats (iClear_stats),
`endif
        .oBusy        (oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic [63:0] d,
                         input logic s, input logic e, input logic [7:0] be);
        iValid[n]            = v;
        iSop[n]              = s;
        iEop[n]              = e;
        iPacket[n*64 +: 64]  = d;
        iByte_enable[n*8 +: 8] = be;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic s,
                            input logic e, input logic [63:0] d);
        chk({tag, ".valid"}, 64'(oValid), 64'(v));
        chk({tag, ".sop"},   64'(oSop),   64'(s));
        chk({tag, ".eop"},   64'(oEop),   64'(e));
        chk({tag, ".data"},  oPacket,     d);
    endtask

    task automatic chk_ctl(input string tag, input logic busy, input logic g,
                           input logic [N-1:0] rdy);
        chk({tag, ".busy"},  64'(oBusy),  64'(busy));
        chk({tag, ".grant"}, 64'(oGrant), 64'(g));
        chk({tag, ".ready"}, 64'(oReady), 64'(rdy));
    endtask

    initial begin
        iReset       = 1'b1;
        iValid       = '0;
        iSop         = '0;
        iEop         = '0;
        iPacket      = '0;
        iByte_enable = '0;
`ifdef PACKET_ARBITER_STATS_EN
        iClear_stats = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        chk_beat("rst", 1'b0, 1'b0, 1'b0, 64'h0);
        chk("rst.be", 64'(oByte_enable), 64'h0);
        chk_ctl("rst", 1'b0, 1'b0, 2'b00);
        iReset = 1'b0;
        tick();

        // Single source 0, three beats 11/22/33
        drive(0, 1, 64'h11, 1, 0, 8'h00);
        tick();
        chk_ctl("p1.grant", 1'b1, 1'b0, 2'b01);
        chk("p1.gvalid", 64'(oValid), 64'h0);
        tick();
        chk_beat("p1.b0", 1'b1, 1'b1, 1'b0, 64'h11);
        drive(0, 1, 64'h22, 0, 0, 8'h00);
        tick();
        chk_beat("p1.b1", 1'b1, 1'b0, 1'b0, 64'h22);
        drive(0, 1, 64'h33, 0, 1, 8'hFF);
        tick();
        chk_beat("p1.b2", 1'b1, 1'b0, 1'b1, 64'h33);
        chk("p1.be", 64'(oByte_enable), 64'hFF);
        chk_ctl("p1.idle", 1'b0, 1'b0, 2'b00);
        drive(0, 0, 64'h33, 0, 0, 8'hFF);
        tick();
        chk_beat("p1.hold", 1'b0, 1'b0, 1'b0, 64'h33);
        chk("p1.hold_be", 64'(oByte_enable), 64'hFF);

        // Valid without sop in IDLE is ignored
        drive(0, 1, 64'h44, 0, 0, 8'h00);
        tick();
        chk_ctl("nosop", 1'b0, 1'b0, 2'b00);
        tick();
        chk_beat("nosop", 1'b0, 1'b0, 1'b0, 64'h33);
        drive(0, 0, 64'h0, 0, 0, 8'h00);

        // Fresh reset, then both sources sop together
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        drive(0, 1, 64'hA1, 1, 0, 8'h00);
        drive(1, 1, 64'hB1, 1, 1, 8'h0F);
        tick();
        chk_ctl("two.g0", 1'b1, 1'b0, 2'b01);
        tick();
        chk_beat("two.a1", 1'b1, 1'b1, 1'b0, 64'hA1);
        drive(0, 1, 64'hA2, 0, 1, 8'h03);
        tick();
        chk_beat("two.a2", 1'b1, 1'b0, 1'b1, 64'hA2);
        chk_ctl("two.rel", 1'b0, 1'b0, 2'b00);
        drive(0, 0, 64'h0, 0, 0, 8'h00);
        tick();
        chk_beat("two.gap", 1'b0, 1'b0, 1'b0, 64'hA2);
        chk_ctl("two.g1", 1'b1, 1'b1, 2'b10);
        tick();
        chk_beat("two.b1", 1'b1, 1'b1, 1'b1, 64'hB1);
        chk("two.b1be", 64'(oByte_enable), 64'h0F);

        // Both sources stream single-beat packets: rotation 0,1,0
        drive(0, 1, 64'hC0, 1, 1, 8'hFF);
        drive(1, 1, 64'hD0, 1, 1, 8'hFF);
        tick();
        chk("rr.g0", 64'(oGrant), 64'h0);
        tick();
        chk_beat("rr.c0", 1'b1, 1'b1, 1'b1, 64'hC0);
        tick();
        chk("rr.g1", 64'(oGrant), 64'h1);
        tick();
        chk_beat("rr.d0", 1'b1, 1'b1, 1'b1, 64'hD0);
        tick();
        chk("rr.g0b", 64'(oGrant), 64'h0);
        tick();
        chk_beat("rr.c0b", 1'b1, 1'b1, 1'b1, 64'hC0);
        drive(0, 0, 64'h0, 0, 0, 8'h00);
        drive(1, 0, 64'h0, 0, 0, 8'h00);

        // Source 1 stalls three cycles mid-packet while source 0 waits
        drive(1, 1, 64'hE1, 1, 0, 8'h00);
        drive(0, 1, 64'hF1, 1, 1, 8'h01);
        tick();
        chk_ctl("stall.g", 1'b1, 1'b1, 2'b10);
        tick();
        chk_beat("stall.e1", 1'b1, 1'b1, 1'b0, 64'hE1);
        drive(1, 0, 64'h0, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_beat("stall.gap", 1'b0, 1'b0, 1'b0, 64'hE1);
            chk_ctl("stall.gap", 1'b1, 1'b1, 2'b10);
        end
        drive(1, 1, 64'hE2, 0, 1, 8'h7F);
        tick();
        chk_beat("stall.e2", 1'b1, 1'b0, 1'b1, 64'hE2);
        chk("stall.be", 64'(oByte_enable), 64'h7F);
        drive(1, 0, 64'h0, 0, 0, 8'h00);
        tick();
        chk_ctl("stall.g0", 1'b1, 1'b0, 2'b01);
        tick();
        chk_beat("stall.f1", 1'b1, 1'b1, 1'b1, 64'hF1);
        drive(0, 0, 64'h0, 0, 0, 8'h00);

        // Reset pulse on beat 2 of a 4-beat packet
        drive(0, 1, 64'h51, 1, 0, 8'h00);
        tick();
        chk_ctl("trunc.g", 1'b1, 1'b0, 2'b01);
        tick();
        chk_beat("trunc.b1", 1'b1, 1'b1, 1'b0, 64'h51);
        drive(0, 1, 64'h52, 0, 0, 8'h00);
        #2;
        iReset = 1'b1;
        #1;
        chk_beat("trunc.rst", 1'b0, 1'b0, 1'b0, 64'h0);
        chk_ctl("trunc.rst", 1'b0, 1'b0, 2'b00);
        #1;
        iReset = 1'b0;
        drive(0, 0, 64'h0, 0, 0, 8'h00);
        tick();
        chk_beat("trunc.after", 1'b0, 1'b0, 1'b0, 64'h0);
        drive(0, 1, 64'h61, 1, 0, 8'h00);
        tick();
        chk_ctl("rec.g", 1'b1, 1'b0, 2'b01);
        tick();
        chk_beat("rec.r1", 1'b1, 1'b1, 1'b0, 64'h61);
        drive(0, 1, 64'h62, 0, 1, 8'h3C);
        tick();
        chk_beat("rec.r2", 1'b1, 1'b0, 1'b1, 64'h62);
        chk("rec.be", 64'(oByte_enable), 64'h3C);
        drive(0, 0, 64'h0, 0, 0, 8'h00);

`ifdef PACKET_ARBITER_STATS_EN
        // Five single-beat packets from source 1, then clear
        drive(1, 1, 64'h77, 1, 1, 8'hFF);
        repeat (10) tick();
        drive(1, 0, 64'h0, 0, 0, 8'h00);
        chk("stats.src1", 64'(oPkt_count[16 +: 16]), 64'd5);
        chk("stats.src0", 64'(oPkt_count[0 +: 16]), 64'd1);
        iClear_stats = 1'b1;
        tick();
        iClear_stats = 1'b0;
        chk("stats.clr1", 64'(oPkt_count[16 +: 16]), 64'd0);
        chk("stats.clr0", 64'(oPkt_count[0 +: 16]), 64'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
